// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter in front of a syn_fifo write port
//
// Optional feature macro: FIFO_ARB_STATS_EN (adds the stall_cnt statistics port).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_data    per-channel producer beats, channel i at req_data[i*DW +: DW]
//   req_ready             per-channel accept, only the granted channel can be ready
//   fifo_full             FIFO full flag
//   fifo_wen/fifo_din     FIFO write strobe and data
//   grant_valid/grant_id  current grant (registered)
//   stall_cnt             saturating count of cycles a granted beat waited on full

module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wen,
    output logic [DW-1:0]           fifo_din,
    output logic                    grant_valid,
    output logic [$clog2(NREQ)-1:0] grant_id
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [BW-1:0]   beat_cnt;
    logic            pick_found;
    logic [IW-1:0]   pick_id;
    logic            sel_valid;

    // Scan last+1, last+2, ... wrapping; iterating downward lets the
    // nearest valid channel overwrite any farther one.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[IW'((int'(last) + k) % NREQ)]) begin
                pick_found = 1'b1;
                pick_id    = IW'((int'(last) + k) % NREQ);
            end
        end
    end

    assign sel_valid = req_valid[grant_id];

    // Reset gates the handshake so a beat offered in the reset cycle is
    // never written even though the state register still reads GRANT.
    assign fifo_wen = (state == GRANT) && sel_valid && !fifo_full && !reset;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == GRANT) && (grant_id == IW'(i)) && !fifo_full && !reset;
        end
    end

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IW'(i)) begin
                fifo_din = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_id    <= '0;
            last        <= IW'(NREQ - 1);
            beat_cnt    <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        grant_id    <= pick_id;
                        last        <= pick_id;
                        beat_cnt    <= '0;
                        grant_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!sel_valid) begin
                        // producer ran dry: release so others get a turn
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end else if (!fifo_full) begin
                        if (beat_cnt == BW'(BURST - 1)) begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                    // full: hold grant and beat count
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((state == GRANT) && sel_valid && fifo_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and randomized checks of fifo_wr_arbiter

module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_wen;
    logic [DW-1:0]     fifo_din;
    logic              grant_valid;
    logic [1:0]        grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wen    (fifo_wen),
        .fifo_din    (fifo_din),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef logic [7:0] q8_t[$];
    q8_t src [NREQ];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int skip     = 1;

    // reference model: which channel holds the grant and how many beats it has used
    int m_gv, m_gid, m_beats, m_last, m_st;

    // write log observed on the FIFO port
    int log_data[$];
    int log_gid[$];
    int log_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gv = 0; m_gid = 0; m_beats = 0; m_last = NREQ - 1; m_st = 0;
    endtask

    // called at posedge+1: drive, check at negedge, advance model, step to next posedge+1
    task automatic cycle();
        logic [NREQ-1:0] v;
        int exp_wen;
        int exp_rdy;
        for (int ch = 0; ch < NREQ; ch++) begin
            v[ch] = (src[ch].size() > 0);
            req_data[ch*DW +: DW] = v[ch] ? src[ch][0] : 8'($urandom);
        end
        req_valid = v;
        @(negedge clk);
        exp_wen = (m_gv != 0 && v[m_gid] && !fifo_full && !reset) ? 1 : 0;
        exp_rdy = (m_gv != 0 && !fifo_full && !reset) ? (1 << m_gid) : 0;
        if (skip == 0) begin
            chk("grant_valid", 32'(grant_valid), 32'(m_gv));
            chk("grant_id",    32'(grant_id),    32'(m_gid));
            chk("fifo_wen",    32'(fifo_wen),    32'(exp_wen));
            chk("req_ready",   32'(req_ready),   32'(exp_rdy));
            chk("fifo_din",    32'(fifo_din),    32'(req_data[m_gid*DW +: DW]));
`ifdef FIFO_ARB_STATS_EN
            chk("stall_cnt",   32'(stall_cnt),   32'(m_st));
`endif
        end
        if (fifo_wen === 1'b1) begin
            log_data.push_back(int'(fifo_din));
            log_gid.push_back(int'(grant_id));
            log_cyc.push_back(cyc);
        end
        if (exp_wen != 0) void'(src[m_gid].pop_front());
        if (reset) begin
            model_reset();
        end else begin
            if (m_gv != 0 && v[m_gid] && fifo_full && m_st < 65535) m_st++;
            if (m_gv == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_gv == 0 && v[(m_last + k) % NREQ]) begin
                        m_gv = 1; m_gid = (m_last + k) % NREQ; m_last = m_gid; m_beats = 0;
                    end
                end
            end else if (!v[m_gid]) begin
                m_gv = 0;
            end else if (!fifo_full) begin
                m_beats++;
                if (m_beats == BURST) m_gv = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_and_reset();
        for (int ch = 0; ch < NREQ; ch++) src[ch].delete();
        fifo_full = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        log_data.delete(); log_gid.delete(); log_cyc.delete();
    endtask

    initial begin
        int c0;
        int n3;
        int exp_off[$];
        int exp_dat[$];
        reset = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        skip = 0;

        // reset state with every channel offering data
        for (int ch = 0; ch < NREQ; ch++) src[ch].push_back(8'h5A);
        cycle();
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id",    32'(grant_id),    32'd0);
        chk("rst_fifo_wen",    32'(fifo_wen),    32'd0);
        chk("rst_req_ready",   32'(req_ready),   32'd0);

        // single burst on ch0: A,8,5,1 then one bubble then 9 in a fresh grant
        clear_and_reset();
        c0 = cyc;
        exp_dat = '{8'hA, 8'h8, 8'h5, 8'h1, 8'h9};
        exp_off = '{1, 2, 3, 4, 6};
        for (int i = 0; i < 5; i++) src[0].push_back(8'(exp_dat[i]));
        for (int i = 0; i < 9; i++) cycle();
        chk("single_count", 32'(log_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_data.size(); i++) begin
            chk("single_data", 32'(log_data[i]), 32'(exp_dat[i]));
            chk("single_cyc",  32'(log_cyc[i] - c0), 32'(exp_off[i]));
            chk("single_gid",  32'(log_gid[i]), 32'd0);
        end

        // round robin from reset: 0,1,2,3,0,... each burst 4 beats, 4 beats per 5 cycles
        clear_and_reset();
        for (int ch = 0; ch < NREQ; ch++)
            for (int i = 0; i < 8; i++) src[ch].push_back(8'(8'h11 * (ch + 1)));
        for (int i = 0; i < 30; i++) cycle();
        chk("rr_count", 32'(log_data.size()), 32'd24);
        for (int k = 0; k < 20 && k < log_data.size(); k++) begin
            chk("rr_gid",  32'(log_gid[k]),  32'((k / 4) % 4));
            chk("rr_data", 32'(log_data[k]), 32'(8'h11 * ((k / 4) % 4 + 1)));
        end

        // full for 3 cycles at beat 2 of a ch2 burst
        clear_and_reset();
        c0 = cyc;
        for (int i = 0; i < 4; i++) src[2].push_back(8'(8'hC0 + i));
        for (int i = 0; i < 3; i++) cycle();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("full_count", 32'(log_data.size()), 32'd4);
        exp_off = '{1, 2, 6, 7};
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            chk("full_gid",  32'(log_gid[i]), 32'd2);
            chk("full_cyc",  32'(log_cyc[i] - c0), 32'(exp_off[i]));
            chk("full_data", 32'(log_data[i]), 32'(8'hC0 + i));
        end
`ifdef FIFO_ARB_STATS_EN
        chk("full_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

        // valid drop on ch1 after 2 beats; ch2 waiting gets the next grant
        clear_and_reset();
        c0 = cyc;
        src[1].push_back(8'hB0); src[1].push_back(8'hB1);
        for (int i = 0; i < 3; i++) src[2].push_back(8'(8'hD0 + i));
        for (int i = 0; i < 10; i++) cycle();
        exp_off = '{1, 2, 5, 6, 7};
        exp_dat = '{1, 1, 2, 2, 2};
        chk("drop_count", 32'(log_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_data.size(); i++) begin
            chk("drop_gid", 32'(log_gid[i]), 32'(exp_dat[i]));
            chk("drop_cyc", 32'(log_cyc[i] - c0), 32'(exp_off[i]));
        end
        // ch1 alone reasserts and is granted again
        log_data.delete(); log_gid.delete(); log_cyc.delete();
        c0 = cyc;
        src[1].push_back(8'hB2); src[1].push_back(8'hB3);
        for (int i = 0; i < 5; i++) cycle();
        chk("reassert_count", 32'(log_data.size()), 32'd2);
        if (log_data.size() > 0) begin
            chk("reassert_gid", 32'(log_gid[0]), 32'd1);
            chk("reassert_cyc", 32'(log_cyc[0] - c0), 32'd1);
        end

        // reset during ch3 beat 1
        clear_and_reset();
        for (int ch = 0; ch < NREQ; ch++)
            for (int i = 0; i < 8; i++) src[ch].push_back(8'(8'h60 + ch));
        for (int i = 0; i < 17; i++) cycle();
        reset = 1'b1;
        cycle();
        n3 = 0;
        foreach (log_gid[i]) if (log_gid[i] == 3) n3++;
        chk("midrst_ch3_beats", 32'(n3), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_grant_valid", 32'(grant_valid), 32'd0);
        chk("midrst_fifo_wen",    32'(fifo_wen),    32'd0);
        chk("midrst_req_ready",   32'(req_ready),   32'd0);
        log_data.delete(); log_gid.delete(); log_cyc.delete();
        for (int i = 0; i < 6; i++) cycle();
        chk("midrst_first_count_nz", 32'(log_gid.size() > 0), 32'd1);
        if (log_gid.size() > 0) chk("midrst_first_gid", 32'(log_gid[0]), 32'd0);

        // randomized traffic, back-pressure and resets against the model
        clear_and_reset();
        for (int n = 0; n < 800; n++) begin
            for (int ch = 0; ch < NREQ; ch++)
                if ($urandom_range(2) == 0 && src[ch].size() < 6) src[ch].push_back(8'($urandom));
            fifo_full = ($urandom_range(3) == 0);
            reset = ($urandom_range(63) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `syn_fifo` write port (`wen`/`din`/`full`) between NREQ producer channels. Each producer uses a valid/ready handshake, and the arbiter grants one channel at a time for a bounded burst. The arbiter sits directly in front of the FIFO's write side. The FIFO read side is untouched.

## Interface
- `NREQ`, default 4: number of producer channels; legal range 2..8.
- `DW`, default 8: data width; must match the FIFO `din` width.
- `BURST`, default 4: maximum beats accepted per grant; legal range 1..16.
- `clk`  in  1: rising-edge clock, the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: per-channel data valid.
- `req_data`  in  NREQ*DW: channel i occupies bits [i*DW +: DW].
- `req_ready`  out  NREQ: per-channel accept; a beat transfers when valid && ready.
- `fifo_full`  in  1: the FIFO `full` flag.
- `fifo_wen`  out  1: drives the FIFO `wen`.
- `fifo_din`  out  DW: drives the FIFO `din`.
- `grant_valid`  out  1: high while the arbiter is in GRANT.
- `grant_id`  out  $clog2(NREQ): index of the granted channel.
- `stall_cnt`  out  16: stall statistics; present only with FIFO_ARB_STATS_EN.

## Operation
- FSM has two states: IDLE and GRANT.
- **IDLE**
  - If any `req_valid` is high, pick the first valid channel scanning from `last+1` upward, wrapping modulo NREQ.
  - Register the pick into `grant_id` and `last`, clear `beat_cnt`, and go to GRANT.
  - If no channel is valid, stay in IDLE.
- **GRANT**
  - `req_ready[grant_id]` = ~`fifo_full`. All other `req_ready` bits are 0.
  - `fifo_wen` = `req_valid[grant_id]` & ~`fifo_full`.
  - `fifo_din` = `req_data` slice of `grant_id` (combinational, valid in all states).
- **Accepted beat** (`fifo_wen` = 1):
  - If `beat_cnt` == BURST-1, go to IDLE.
  - Otherwise increment `beat_cnt`.
- **Valid drop:** if `req_valid[grant_id]` = 0 in GRANT, go to IDLE. No write occurs that cycle.
- **FIFO full:** with `fifo_full` = 1 in GRANT, hold state, `beat_cnt` and grant. `fifo_wen` = 0. The grant is not released because of full.
- **Fairness:** because each grant ends in IDLE, a continuously-valid channel yields to every other valid channel between bursts.
- **`beat_cnt` width:** $clog2(BURST)+1 bits. It never exceeds BURST-1.
- **Reset** (synchronous, takes effect regardless of state, including mid-burst):
  - State = IDLE, `grant_id` = 0, `beat_cnt` = 0, `last` = NREQ-1 (so channel 0 has first priority), `stall_cnt` = 0.
  - Resulting outputs: `grant_valid` = 0, `fifo_wen` = 0, `req_ready` = 0.
  - A beat presented in the reset cycle is not accepted.

## Timing
- Arbitration costs one cycle. A request first seen valid in IDLE at cycle N can have its first beat written at cycle N+1 at the earliest.
- Write path is zero-latency. The accepted beat appears on `fifo_wen`/`fifo_din` in the same cycle as the handshake.
- Per-burst throughput: 1 beat/cycle while `fifo_full` = 0.
- Back-to-back bursts have one IDLE bubble between them. Sustained rate with BURST=4 and all channels valid is 4 beats per 5 cycles.
- `fifo_full` feeds into `req_ready`/`fifo_wen` combinationally. No registered write is issued on a stale flag.

## Configuration
- Macro: **FIFO_ARB_STATS_EN**.
- **Defined:** `stall_cnt` is a 16-bit saturating counter.
  - It increments in each cycle where state = GRANT, `req_valid[grant_id]` = 1 and `fifo_full` = 1.
  - It saturates at 16'hFFFF and is cleared by `reset`.
- **Undefined:** the `stall_cnt` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Single burst:** after reset, only ch0 valid with data 8'hA,8'h8,8'h5,8'h1,8'h9 and `fifo_full`=0.
  - `grant_valid` rises 1 cycle after valid.
  - `fifo_wen` is high for 4 cycles writing A,8,5,1.
  - One IDLE cycle follows, then 9 is written in a new grant to ch0.
- **Round robin:** NREQ=4 with all channels continuously valid, each sourcing a unique constant data value.
  - `grant_id` sequence is 0,1,2,3,0.
  - Each grant lasts 4 write beats carrying that channel's data.
- **Full stall:** `fifo_full`=1 for 3 cycles mid-burst on ch2 at beat 2.
  - `fifo_wen`=0 and `req_ready`=0 while full; `grant_id` stays 2.
  - The burst resumes and completes with exactly 4 total beats.
  - With FIFO_ARB_STATS_EN, `stall_cnt`=3.
- **Valid drop:** ch1 granted, valid deasserts after 2 beats.
  - Arbiter returns to IDLE in that cycle.
  - Next grant goes to ch2 if valid; otherwise to ch1 when it reasserts.
- **Reset mid-burst:** assert `reset` during ch3 beat 1.
  - Next cycle: `grant_valid`=0, `fifo_wen`=0, `req_ready`=0.
  - After release, with all channels valid, the first grant is ch0.
